// File: rtl/agc_timepulse_gen_if.sv
// rtl/agc_timepulse_gen_if.sv - monitor/timing bundle between the AGC timepulse generator and its users
interface agc_timepulse_gen_if #(
  parameter int PHASES_PER_T = 4,
  parameter int NUM_T        = 12,
  parameter int CNT_W        = 16
);
  logic                    stop_req;
  logic                    step_req;
  logic [NUM_T-1:0]        t_pulse;
  logic [PHASES_PER_T-1:0] phase;
  logic                    mct_end;
  logic                    stopped;
  logic [CNT_W-1:0]        mct_count;

  // Monitor side: issues stop/step requests and observes the timing outputs.
  modport master (
    output stop_req, step_req,
    input  t_pulse, phase, mct_end, stopped, mct_count
  );

  // Generator side.
  modport slave (
    input  stop_req, step_req,
    output t_pulse, phase, mct_end, stopped, mct_count
  );
endinterface

// File: rtl/agc_timepulse_gen.sv
// rtl/agc_timepulse_gen.sv - AGC master timepulse generator (T01..T12, phases, MCT end, stop/step); TPG_STEP_EN enables single-step
module agc_timepulse_gen #(
  parameter int PHASES_PER_T = 4,
  parameter int NUM_T        = 12,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic vcc,
  input  logic gnd,
  agc_timepulse_gen_if.slave bus
);

  localparam logic [NUM_T-1:0]        T_FIRST  = NUM_T'(1);
  localparam logic [PHASES_PER_T-1:0] PH_FIRST = PHASES_PER_T'(1);

`ifdef TPG_STEP_EN
  typedef enum logic [1:0] {S_RUN, S_HALT, S_STEP} state_t;
`else
  typedef enum logic {S_RUN, S_HALT} state_t;
`endif

  state_t                  state;
  logic [PHASES_PER_T-1:0] phase_nxt;
  logic [NUM_T-1:0]        t_nxt;

`ifdef TPG_STEP_EN
  logic step_q;
  logic step_edge;
  logic unused_pins;
  assign step_edge   = bus.step_req & ~step_q;
  assign unused_pins = vcc ^ gnd;
`else
  // Power pins and the step request have no function in this build.
  logic unused_pins;
  assign unused_pins = vcc ^ gnd ^ bus.step_req;
`endif

  // Next phase/timepulse while running: phase rotates every clock, the
  // timepulse rotates only when the phase wraps out of its last bit.
  always_comb begin
    phase_nxt = {bus.phase[PHASES_PER_T-2:0], bus.phase[PHASES_PER_T-1]};
    t_nxt     = bus.t_pulse;
    if (bus.phase[PHASES_PER_T-1]) begin
      t_nxt = {bus.t_pulse[NUM_T-2:0], bus.t_pulse[NUM_T-1]};
    end
  end

  // Run/halt/step sequencer with all outputs registered; mct_end is
  // precomputed from the next timing state so it lines up with the last phase of T12.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_RUN;
      bus.t_pulse   <= T_FIRST;
      bus.phase     <= PH_FIRST;
      bus.mct_end   <= 1'b0;
      bus.stopped   <= 1'b0;
      bus.mct_count <= '0;
`ifdef TPG_STEP_EN
      step_q        <= 1'b0;
`endif
    end else begin
`ifdef TPG_STEP_EN
      step_q <= bus.step_req;
`endif
      case (state)
        S_HALT: begin
          // Release dominates a simultaneous step edge.
          if (!bus.stop_req) begin
            state       <= S_RUN;
            bus.t_pulse <= T_FIRST;
            bus.phase   <= PH_FIRST;
            bus.stopped <= 1'b0;
          end
`ifdef TPG_STEP_EN
          else if (step_edge) begin
            state       <= S_STEP;
            bus.t_pulse <= T_FIRST;
            bus.phase   <= PH_FIRST;
            bus.stopped <= 1'b0;
          end
`endif
        end
        default: begin
          // RUN and STEP share timing; stop_req matters only at the MCT boundary.
          if (bus.mct_end) begin
            bus.mct_count <= bus.mct_count + CNT_W'(1);
            bus.mct_end   <= 1'b0;
            if (bus.stop_req) begin
              state       <= S_HALT;
              bus.t_pulse <= '0;
              bus.phase   <= '0;
              bus.stopped <= 1'b1;
            end else begin
              state       <= S_RUN;
              bus.t_pulse <= T_FIRST;
              bus.phase   <= PH_FIRST;
            end
          end else begin
            bus.t_pulse <= t_nxt;
            bus.phase   <= phase_nxt;
            bus.mct_end <= t_nxt[NUM_T-1] & phase_nxt[PHASES_PER_T-1];
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_agc_timepulse_gen.sv
// tb/tb_agc_timepulse_gen.sv - self-checking bench for agc_timepulse_gen
module tb_agc_timepulse_gen;

  localparam int PH      = 4;
  localparam int NT      = 12;
  localparam int MCT_LEN = PH * NT;

  logic clk;
  logic rst;

  agc_timepulse_gen_if #(.PHASES_PER_T(PH), .NUM_T(NT), .CNT_W(16)) bus ();
  agc_timepulse_gen_if #(.PHASES_PER_T(PH), .NUM_T(NT), .CNT_W(4))  bus4 ();

  agc_timepulse_gen #(.PHASES_PER_T(PH), .NUM_T(NT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .vcc(1'b1), .gnd(1'b0), .bus(bus.slave)
  );

  agc_timepulse_gen #(.PHASES_PER_T(PH), .NUM_T(NT), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .vcc(1'b1), .gnd(1'b0), .bus(bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  int cyc;

  // Reference model: position within the MCT plus a mode word.
  localparam int M_RUN = 0, M_HALT = 1, M_STEP = 2;
  int m_mode;
  int m_pos;
  int m_cnt;
  bit m_prev_step;

  typedef struct {
    logic        r, s, st;
    logic [11:0] t;
    logic [3:0]  ph;
    logic        e, sp;
    logic [15:0] c;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(input logic r, input logic s, input logic st);
    bit edge_seen;
    if (r) begin
      m_mode = M_RUN; m_pos = 0; m_cnt = 0; m_prev_step = 1'b0;
      return;
    end
`ifdef TPG_STEP_EN
    edge_seen = st && !m_prev_step;
`else
    edge_seen = 1'b0;
`endif
    m_prev_step = st;
    if (m_mode == M_HALT) begin
      if (!s) begin
        m_mode = M_RUN; m_pos = 0;
      end else if (edge_seen) begin
        m_mode = M_STEP; m_pos = 0;
      end
    end else if (m_pos == MCT_LEN - 1) begin
      m_cnt++;
      m_pos  = 0;
      m_mode = s ? M_HALT : M_RUN;
    end else begin
      m_pos++;
    end
  endtask

  task automatic check_model();
    bit halted;
    halted = (m_mode == M_HALT);
    chk("t_pulse", 32'(bus.t_pulse), halted ? 32'd0 : (32'd1 << (m_pos / PH)));
    chk("phase",   32'(bus.phase),   halted ? 32'd0 : (32'd1 << (m_pos % PH)));
    chk("mct_end", 32'(bus.mct_end), 32'(!halted && m_pos == MCT_LEN - 1));
    chk("stopped", 32'(bus.stopped), 32'(halted));
    chk("mct_count", 32'(bus.mct_count), 32'(m_cnt % 65536));
    chk("mct_count4", 32'(bus4.mct_count), 32'(m_cnt % 16));
  endtask

  task automatic cycle(input logic r, input logic s, input logic st, input bit do_check);
    rst = r;
    bus.stop_req = s;  bus.step_req = st;
    bus4.stop_req = s; bus4.step_req = st;
    @(posedge clk);
    model_step(r, s, st);
    #1;
    if (r) cyc = 0; else cyc++;
    if (do_check) check_model();
  endtask

  int ends;
  int active;
  logic rs, ss, sts;

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    m_mode = M_RUN; m_pos = 0; m_cnt = 0; m_prev_step = 1'b0;
    rst = 1'b0;
    bus.stop_req = 1'b0;  bus.step_req = 1'b0;
    bus4.stop_req = 1'b0; bus4.step_req = 1'b0;

    tbl[0] = '{r:1'b1, s:1'b0, st:1'b0, t:12'h001, ph:4'h1, e:1'b0, sp:1'b0, c:16'd0};
    tbl[1] = '{r:1'b0, s:1'b0, st:1'b0, t:12'h001, ph:4'h2, e:1'b0, sp:1'b0, c:16'd0};
    tbl[2] = '{r:1'b0, s:1'b0, st:1'b0, t:12'h001, ph:4'h4, e:1'b0, sp:1'b0, c:16'd0};
    tbl[3] = '{r:1'b0, s:1'b0, st:1'b0, t:12'h001, ph:4'h8, e:1'b0, sp:1'b0, c:16'd0};
    tbl[4] = '{r:1'b0, s:1'b0, st:1'b0, t:12'h002, ph:4'h1, e:1'b0, sp:1'b0, c:16'd0};
    tbl[5] = '{r:1'b0, s:1'b0, st:1'b0, t:12'h002, ph:4'h2, e:1'b0, sp:1'b0, c:16'd0};
    tbl[6] = '{r:1'b1, s:1'b0, st:1'b0, t:12'h001, ph:4'h1, e:1'b0, sp:1'b0, c:16'd0};
    tbl[7] = '{r:1'b0, s:1'b1, st:1'b1, t:12'h001, ph:4'h2, e:1'b0, sp:1'b0, c:16'd0};

    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].r, tbl[i].s, tbl[i].st, 1'b0);
      chk("tbl_t_pulse", 32'(bus.t_pulse), 32'(tbl[i].t));
      chk("tbl_phase",   32'(bus.phase),   32'(tbl[i].ph));
      chk("tbl_mct_end", 32'(bus.mct_end), 32'(tbl[i].e));
      chk("tbl_stopped", 32'(bus.stopped), 32'(tbl[i].sp));
      chk("tbl_count",   32'(bus.mct_count), 32'(tbl[i].c));
    end

    // Free run, including CNT_W=4 wrap after 16 MCTs.
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    ends = 0;
    while (cyc < 16 * MCT_LEN) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      if (cyc < 100) begin
        chk("free_end_pos", 32'(bus.mct_end), 32'(cyc == 47 || cyc == 95));
        if (bus.mct_end) ends++;
      end
      if (cyc == 3)  chk("free_t_c3", 32'(bus.t_pulse), 32'h1);
      if (cyc == 4)  chk("free_t_c4", 32'(bus.t_pulse), 32'h2);
      if (cyc == 96) chk("free_cnt_c96", 32'(bus.mct_count), 32'd2);
      if (cyc == 100) chk("free_end_total", 32'(ends), 32'd2);
    end
    chk("wrap_cnt16", 32'(bus.mct_count), 32'd16);
    chk("wrap_cnt4",  32'(bus4.mct_count), 32'd0);

    // Mid-MCT stop then resume.
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    while (cyc < 112) begin
      cycle(1'b0, (cyc >= 10 && cyc < 60), 1'b0, 1'b1);
      if (cyc == 47)  chk("stop_end_c47", 32'(bus.mct_end), 32'd1);
      if (cyc == 48) begin
        chk("stop_stopped_c48", 32'(bus.stopped), 32'd1);
        chk("stop_t_c48", 32'(bus.t_pulse), 32'd0);
        chk("stop_cnt_c48", 32'(bus.mct_count), 32'd1);
      end
      if (cyc == 60) chk("stop_cnt_c60", 32'(bus.mct_count), 32'd1);
      if (cyc == 61) begin
        chk("resume_t_c61", 32'(bus.t_pulse), 32'd1);
        chk("resume_ph_c61", 32'(bus.phase), 32'd1);
        chk("resume_stopped_c61", 32'(bus.stopped), 32'd0);
      end
      if (cyc == 108) chk("resume_end_c108", 32'(bus.mct_end), 32'd1);
    end

    // stop_req held across reset, then single step with an ignored second pulse.
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    active = 0;
    while (cyc < 130) begin
      cycle(1'b0, 1'b1, (cyc == 60 || cyc == 80), 1'b1);
      if (cyc == 47) chk("hold_end_c47", 32'(bus.mct_end), 32'd1);
      if (cyc == 48) chk("hold_stopped_c48", 32'(bus.stopped), 32'd1);
      if (cyc > 48 && !bus.stopped) active++;
`ifdef TPG_STEP_EN
      if (cyc == 61)  chk("step_t_c61", 32'(bus.t_pulse), 32'd1);
      if (cyc == 108) chk("step_end_c108", 32'(bus.mct_end), 32'd1);
      if (cyc == 109) begin
        chk("step_halt_c109", 32'(bus.stopped), 32'd1);
        chk("step_cnt_c109", 32'(bus.mct_count), 32'd2);
      end
`else
      if (cyc == 61) chk("nostep_stopped_c61", 32'(bus.stopped), 32'd1);
`endif
    end
`ifdef TPG_STEP_EN
    chk("step_active_cycles", 32'(active), 32'd48);
`else
    chk("step_active_cycles", 32'(active), 32'd0);
`endif
    chk("step_halted_c130", 32'(bus.stopped), 32'd1);

    // Simultaneous release and step edge while halted.
    while (cyc < 250) begin
      cycle(1'b0, (cyc < 139), (cyc == 139), 1'b1);
      if (cyc == 140) chk("rel_run_c140", 32'(bus.stopped), 32'd0);
      if (cyc == 200) chk("rel_run_c200", 32'(bus.stopped), 32'd0);
    end

    // Reset part-way through the second MCT.
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    while (cyc < 78) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_pre_cnt", 32'(bus.mct_count), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_cnt", 32'(bus.mct_count), 32'd0);
    chk("rst_t", 32'(bus.t_pulse), 32'd1);
    chk("rst_ph", 32'(bus.phase), 32'd1);
    ends = 0;
    while (cyc < 47) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      if (bus.mct_end && cyc < 47) ends++;
    end
    chk("rst_no_early_end", 32'(ends), 32'd0);
    chk("rst_end_c47", 32'(bus.mct_end), 32'd1);

    // Randomised run against the reference model.
    ss = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rs = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 39) == 0) ss = ~ss;
      sts = ($urandom_range(0, 11) == 0);
      cycle(rs, ss, sts, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
